// File: rtl/pov_raydir.sv
`default_nettype none
// ============================================================================
// Module   : pov_raydir
// Purpose  : Per-column ray-direction generator for the wall tracer.
//            rayDir(c) = facing + vplane*(2c/COLS - 1), evaluated without a
//            multiplier. Once per frame a serial shift-add multiply forms the
//            per-column step (vplane * STEP_RECIP). After that, each column
//            costs one accumulator add.
// Ports    : clk, reset (sync, active-high)
//            facingX/Y, vplaneX/Y - SQ10.10 vectors from the POV block
//            frame_start          - latch vectors, start step multiply
//            line_start           - rewind to column 0
//            col_advance          - step to next column (saturates at COLS-1)
//            rayDirX/Y            - SQ10.10 ray direction of current column
//            col                  - current column index
//            valid / busy         - column ray valid / step multiply running
// Revision : 1.0 - initial release
// ============================================================================
module pov_raydir #(
  parameter int COLS        = 640,
  parameter int RECIP_SHIFT = 16,
  parameter int RECIP_W     = 8,
  parameter int STEP_RECIP  = 205
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [19:0] facingX,
  input  logic signed [19:0] facingY,
  input  logic signed [19:0] vplaneX,
  input  logic signed [19:0] vplaneY,
  input  logic               frame_start,
  input  logic               line_start,
  input  logic               col_advance,
  output logic signed [19:0] rayDirX,
  output logic signed [19:0] rayDirY,
  output logic [9:0]         col,
  output logic               valid,
  output logic               busy
);

  // Two guard bits above the SQ10.10 range plus the extra fraction bits.
  localparam int ACC_W = 20 + RECIP_SHIFT + 2;
  localparam int BIT_W = (RECIP_W > 1) ? $clog2(RECIP_W) : 1;

  localparam logic [RECIP_W-1:0] C_RECIP    = RECIP_W'(STEP_RECIP);
  localparam logic [BIT_W-1:0]   C_LAST_BIT = BIT_W'(RECIP_W - 1);
  localparam logic [9:0]         C_LAST_COL = 10'(COLS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic signed [19:0]       vx_q, vx_d;
  logic signed [19:0]       vy_q, vy_d;
  logic signed [ACC_W-1:0]  basex_q, basex_d;
  logic signed [ACC_W-1:0]  basey_q, basey_d;
  logic signed [ACC_W-1:0]  stepx_q, stepx_d;
  logic signed [ACC_W-1:0]  stepy_q, stepy_d;
  logic signed [ACC_W-1:0]  accx_q, accx_d;
  logic signed [ACC_W-1:0]  accy_q, accy_d;
  logic [BIT_W-1:0]         bit_q, bit_d;
  logic [9:0]               col_q, col_d;

  function automatic logic signed [ACC_W-1:0] sext(input logic signed [19:0] a);
    return {{(ACC_W-20){a[19]}}, a};
  endfunction

  always_comb begin
    state_d = state_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    basex_d = basex_q;
    basey_d = basey_q;
    stepx_d = stepx_q;
    stepy_d = stepy_q;
    accx_d  = accx_q;
    accy_d  = accy_q;
    bit_d   = bit_q;
    col_d   = col_q;

    case (state_q)
      S_MUL: begin
        // One multiplier bit per cycle, LSB first.
        if (C_RECIP[bit_q]) begin
          stepx_d = stepx_q + (sext(vx_q) <<< bit_q);
          stepy_d = stepy_q + (sext(vy_q) <<< bit_q);
        end
        if (bit_q == C_LAST_BIT) begin
          state_d = S_RUN;
          accx_d  = basex_q;
          accy_d  = basey_q;
          col_d   = 10'd0;
        end else begin
          bit_d = bit_q + BIT_W'(1);
        end
      end
      S_RUN: begin
        if (line_start) begin
          accx_d = basex_q;
          accy_d = basey_q;
          col_d  = 10'd0;
        end else if (col_advance && (col_q != C_LAST_COL)) begin
          accx_d = accx_q + stepx_q;
          accy_d = accy_q + stepy_q;
          col_d  = col_q + 10'd1;
        end
      end
      default: begin
      end
    endcase

    // A new frame overrides anything in progress, including a running multiply.
    if (frame_start) begin
      state_d = S_MUL;
      vx_d    = vplaneX;
      vy_d    = vplaneY;
      basex_d = (sext(facingX) - sext(vplaneX)) <<< RECIP_SHIFT;
      basey_d = (sext(facingY) - sext(vplaneY)) <<< RECIP_SHIFT;
      stepx_d = '0;
      stepy_d = '0;
      bit_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      vx_q    <= '0;
      vy_q    <= '0;
      basex_q <= '0;
      basey_q <= '0;
      stepx_q <= '0;
      stepy_q <= '0;
      accx_q  <= '0;
      accy_q  <= '0;
      bit_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      basex_q <= basex_d;
      basey_q <= basey_d;
      stepx_q <= stepx_d;
      stepy_q <= stepy_d;
      accx_q  <= accx_d;
      accy_q  <= accy_d;
      bit_q   <= bit_d;
      col_q   <= col_d;
    end
  end

  // Slicing above the extra fraction bits is the floor shift; the two guard
  // bits are dropped, so out-of-range values wrap.
  assign rayDirX = accx_q[RECIP_SHIFT +: 20];
  assign rayDirY = accy_q[RECIP_SHIFT +: 20];
  assign col     = col_q;
  assign valid   = (state_q == S_RUN);
  assign busy    = (state_q == S_MUL);

endmodule
`default_nettype wire

// File: tb/tb_pov_raydir.sv
`default_nettype none
// ============================================================================
// Module   : tb_pov_raydir
// Purpose  : Self-checking bench for pov_raydir. Stimulus pushes expected
//            output snapshots tagged with the cycle they apply to; a monitor
//            on the falling edge pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pov_raydir;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic signed [19:0] facingX = '0, facingY = '0, vplaneX = '0, vplaneY = '0;
    logic               frame_start = 1'b0, line_start = 1'b0, col_advance = 1'b0;
    logic signed [19:0] rayDirX, rayDirY;
    logic [9:0]         col;
    logic               valid, busy;

    pov_raydir dut (
        .clk        (clk),
        .reset      (reset),
        .facingX    (facingX),
        .facingY    (facingY),
        .vplaneX    (vplaneX),
        .vplaneY    (vplaneY),
        .frame_start(frame_start),
        .line_start (line_start),
        .col_advance(col_advance),
        .rayDirX    (rayDirX),
        .rayDirY    (rayDirY),
        .col        (col),
        .valid      (valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        int                 cyc;
        string              name;
        logic [9:0]         col;
        logic signed [19:0] rx;
        logic signed [19:0] ry;
        logic               v;
        logic               b;
        logic               rd_care;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
            e = sb.pop_front();
            n_cmp++;
            if (e.cyc != cyc_cnt || col !== e.col || valid !== e.v || busy !== e.b ||
                (e.rd_care && (rayDirX !== e.rx || rayDirY !== e.ry))) begin
                n_bad++;
                $display("FAIL %s @cyc %0d: got col=%0d rd=(%0d,%0d) v=%b b=%b, want col=%0d rd=(%0d,%0d) v=%b b=%b",
                         e.name, cyc_cnt, col, rayDirX, rayDirY, valid, busy,
                         e.col, e.rx, e.ry, e.v, e.b);
            end
        end
    end

    task automatic step_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int c, input int rx, input int ry,
                       input logic v, input logic b, input logic rd_care);
        exp_t x;
        x.cyc = cyc_cnt;
        x.name = name;
        x.col = 10'(c);
        x.rx = 20'(rx);
        x.ry = 20'(ry);
        x.v = v;
        x.b = b;
        x.rd_care = rd_care;
        sb.push_back(x);
    endtask

    task automatic pulse(input logic fs, input logic ls, input logic ca);
        frame_start = fs;
        line_start  = ls;
        col_advance = ca;
        step_cyc();
        frame_start = 1'b0;
        line_start  = 1'b0;
        col_advance = 1'b0;
    endtask

    task automatic run_frame(input string name, input int rx0, input int ry0,
                             input logic rd_care_mul);
        pulse(1'b1, 1'b0, 1'b0);
        chk({name, "_busy"}, 0, 0, 0, 1'b0, 1'b1, rd_care_mul);
        for (int k = 0; k < 7; k++) begin
            step_cyc();
            chk({name, "_busy"}, 0, 0, 0, 1'b0, 1'b1, rd_care_mul);
        end
        step_cyc();
        chk({name, "_col0"}, 0, rx0, ry0, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        step_cyc();
        step_cyc();
        reset = 1'b0;
        chk("reset", 0, 0, 0, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (rayDirX !== 20'sd0 || rayDirY !== 20'sd0 || col !== 10'd0 ||
            valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL direct_reset: col=%0d rd=(%0d,%0d) v=%b b=%b",
                     col, rayDirX, rayDirY, valid, busy);
        end
        pulse(1'b0, 1'b1, 1'b1);
        chk("idle_ls_ca", 0, 0, 0, 1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b0, 1'b1);
        chk("idle_ca", 0, 0, 0, 1'b0, 1'b0, 1'b1);

        facingX = 20'sd0;    facingY = 20'sd1024;
        vplaneX = -20'sd512; vplaneY = 20'sd0;
        run_frame("nom", 512, 1024, 1'b1);
        n_cmp++;
        if (rayDirX !== 20'sd512 || rayDirY !== 20'sd1024 || col !== 10'd0 ||
            valid !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL direct_nom: col=%0d rd=(%0d,%0d) v=%b b=%b",
                     col, rayDirX, rayDirY, valid, busy);
        end

        facingX = 20'sd777; facingY = -20'sd3; vplaneX = 20'sd99; vplaneY = 20'sd1234;

        pulse(1'b0, 1'b0, 1'b1);
        chk("sweep_c1", 1, 510, 1024, 1'b1, 1'b0, 1'b1);
        col_advance = 1'b1;
        repeat (319) step_cyc();
        col_advance = 1'b0;
        chk("sweep_c320", 320, -1, 1024, 1'b1, 1'b0, 1'b1);
        n_cmp++;
        if (col !== 10'd320 || rayDirX !== -20'sd1 || rayDirY !== 20'sd1024) begin
            n_bad++;
            $display("FAIL direct_c320: col=%0d rd=(%0d,%0d)", col, rayDirX, rayDirY);
        end
        col_advance = 1'b1;
        repeat (319) step_cyc();
        col_advance = 1'b0;
        chk("sweep_c639", 639, -512, 1024, 1'b1, 1'b0, 1'b1);
        pulse(1'b0, 1'b0, 1'b1);
        chk("sweep_sat", 639, -512, 1024, 1'b1, 1'b0, 1'b1);

        pulse(1'b0, 1'b1, 1'b0);
        chk("rewind_ls", 0, 512, 1024, 1'b1, 1'b0, 1'b1);
        col_advance = 1'b1;
        repeat (100) step_cyc();
        col_advance = 1'b0;
        chk("rewind_c100", 100, 351, 1024, 1'b1, 1'b0, 1'b1);
        pulse(1'b0, 1'b1, 1'b1);
        chk("rewind_ls_ca", 0, 512, 1024, 1'b1, 1'b0, 1'b1);
        n_cmp++;
        if (col !== 10'd0 || rayDirX !== 20'sd512 || rayDirY !== 20'sd1024) begin
            n_bad++;
            $display("FAIL direct_rewind: col=%0d rd=(%0d,%0d)", col, rayDirX, rayDirY);
        end

        facingX = 20'sd0;    facingY = 20'sd1024;
        vplaneX = -20'sd512; vplaneY = 20'sd0;
        pulse(1'b1, 1'b0, 1'b0);
        chk("restart_first", 0, 0, 0, 1'b0, 1'b1, 1'b0);
        step_cyc();
        step_cyc();
        vplaneX = 20'sd0; vplaneY = 20'sd512;
        run_frame("restart", 0, 512, 1'b0);
        n_cmp++;
        if (rayDirX !== 20'sd0 || rayDirY !== 20'sd512 || valid !== 1'b1) begin
            n_bad++;
            $display("FAIL direct_restart: rd=(%0d,%0d) v=%b", rayDirX, rayDirY, valid);
        end
        pulse(1'b0, 1'b0, 1'b1);
        chk("restart_c1", 1, 0, 513, 1'b1, 1'b0, 1'b1);
        col_advance = 1'b1;
        repeat (49) step_cyc();
        col_advance = 1'b0;
        chk("restart_c50", 50, 0, 592, 1'b1, 1'b0, 1'b1);

        reset = 1'b1;
        step_cyc();
        reset = 1'b0;
        chk("midrun_reset", 0, 0, 0, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (rayDirX !== 20'sd0 || rayDirY !== 20'sd0 || col !== 10'd0 ||
            valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL direct_midrun_reset: col=%0d rd=(%0d,%0d) v=%b b=%b",
                     col, rayDirX, rayDirY, valid, busy);
        end
        pulse(1'b0, 1'b0, 1'b1);
        chk("post_reset_ca", 0, 0, 0, 1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b1, 1'b0);
        chk("post_reset_ls", 0, 0, 0, 1'b0, 1'b0, 1'b1);
        facingX = 20'sd0;    facingY = 20'sd1024;
        vplaneX = -20'sd512; vplaneY = 20'sd0;
        run_frame("renom", 512, 1024, 1'b1);
        pulse(1'b0, 1'b0, 1'b1);
        chk("renom_c1", 1, 510, 1024, 1'b1, 1'b0, 1'b1);

        repeat (3) step_cyc();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s: expectation for cycle %0d never compared (now %0d)", e.name, e.cyc, cyc_cnt);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pov_raydir.md
# pov_raydir

Per-column ray-direction generator that sits directly downstream of the POV register block. It consumes that block's live `facing` and `vplane` vectors (SQ10.10) and produces one ray-direction vector per screen column for the wall tracer. The two vectors follow `rayDir(c) = facing + vplane*(2c/COLS - 1)`. There is no hardware multiplier or divider. Once per frame a serial shift-add multiply forms the per-column step, and then one accumulator add is done per column.

## Interface
Parameters:
- `COLS`, default 640: columns per line.
- `RECIP_SHIFT`, default 16: extra fraction bits carried in the accumulators.
- `RECIP_W`, default 8: width of `STEP_RECIP`, which also sets the multiply cycle count.
- `STEP_RECIP`, default 205: unsigned constant equal to round(2^RECIP_SHIFT * 2/COLS).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `facingX`, `facingY`, `vplaneX`, `vplaneY`  in  20 each  signed SQ10.10, from the POV block.
- `frame_start`  in  1  one-cycle pulse. Latches the vectors and starts the step computation.
- `line_start`  in  1  one-cycle pulse. Rewinds to column 0.
- `col_advance`  in  1  one-cycle pulse. Steps to the next column.
- `rayDirX`, `rayDirY`  out  20 each  signed SQ10.10 ray direction for the current column.
- `col`  out  10  current column index.
- `valid`  out  1  the outputs hold a correct column ray.
- `busy`  out  1  the step multiply is in progress.

## Operation
- FSM states are IDLE, MUL and RUN. Reset enters IDLE.
- In any state, `frame_start` latches fX, fY, vX, vY and computes `base = (f - v) << RECIP_SHIFT` per axis. It also clears the step accumulators and the bit index, then enters MUL with `busy`=1 and `valid`=0.
- MUL, iteration i = 0..RECIP_W-1: if `STEP_RECIP[i]`, do `step += sign_extend(v) << i` per axis. After the last bit:
  - enter RUN;
  - set `acc = base`, `col` = 0;
  - set `valid`=1, `busy`=0.
- Arithmetic widths:
  - `step` and `acc` are signed, 20+RECIP_SHIFT+2 bits wide.
  - `rayDir = acc >>> RECIP_SHIFT` (arithmetic shift, floor), truncated to 20 bits.
  - Out-of-range values wrap silently; this is not checked.
- RUN, `line_start`: `acc = base`, `col` = 0.
- RUN, `col_advance`: `acc += step`, `col += 1`.
  - At `col` == COLS-1, `col_advance` is ignored: saturate, no wrap.
- `line_start` and `col_advance` in the same cycle: `line_start` wins.
- `line_start` and `col_advance` are ignored in IDLE and MUL.
- Changes on the vector inputs between `frame_start` pulses have no effect.

## Timing
- Reset values:
  - state IDLE;
  - `rayDirX`, `rayDirY`, `col` = 0;
  - `valid`=0, `busy`=0;
  - internal `base`, `step`, `acc` = 0.
- Reset asserted mid-MUL or mid-RUN aborts to these values on the next edge.
- `frame_start` sampled at edge E0:
  - `busy`=1 and `valid`=0 after E0;
  - `valid`=1, `busy`=0 and `col`=0 after edge E0+RECIP_W (8 cycles by default).
- `frame_start` during MUL restarts the computation. The RECIP_W-cycle latency counts from the new pulse.
- `col_advance` and `line_start` take effect at the sampling edge. The new `rayDir` and `col` are visible after that edge (one-cycle registered latency).
- Back-to-back `col_advance` every cycle is supported.

## Test plan
- Post-reset check: assert reset for 2 cycles, then release -> outputs hold 0, `valid`=0, `busy`=0; `line_start` and `col_advance` are ignored.
- Nominal frame: facing=(0,1024), vplane=(-512,0), pulse `frame_start` -> `busy` is high for exactly 8 cycles, then `valid`=1, `col`=0, rayDir=(512,1024).
- Column sweep from that state: 320 `col_advance` pulses -> `col`=320, rayDirX=-1, rayDirY=1024. At 639 pulses -> rayDirX=-512. A 640th pulse leaves `col`=639 and rayDir unchanged.
- Line rewind: `line_start` together with `col_advance` at `col`=100 -> `col`=0, rayDir=(512,1024).
- Restart mid-MUL: change vplane to (0,512) and pulse `frame_start` 3 cycles into MUL -> `valid` rises 8 cycles after the second pulse, with rayDir=(0,512) and facing=(0,1024) as latched.
- Reset mid-RUN at `col`=50 -> all outputs 0, state IDLE. Then `frame_start` reproduces the nominal frame.
